// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: software-loaded pattern/length/overlap,
// valid/ready bit stream, IDLE/RUN/DONE sequencing, match counter and sticky irq.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [MAX_LEN-1:0]               cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len,
    input  logic                             cfg_overlap,
    input  logic [CNT_W-1:0]                 cfg_thresh,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             bit_valid,
    input  logic                             bit_in,
    output logic                             bit_ready,
    output logic                             match,
    output logic [CNT_W-1:0]                 match_cnt,
    output logic                             irq,
    input  logic                             irq_clr,
    output logic                             busy
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Lengths of zero or beyond the history depth fall back to the full depth.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] r;
        if (l == {LEN_W{1'b0}} || l > LEN_W'(MAX_LEN)) begin
            r = LEN_W'(MAX_LEN);
        end else begin
            r = l;
        end
        return r;
    endfunction

    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [MAX_LEN-1:0] m;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(l));
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    state_t               state_r;
    logic [MAX_LEN-1:0]   pattern_r;
    logic [LEN_W-1:0]     len_r;
    logic                 overlap_r;
    logic [CNT_W-1:0]     thresh_r;
    logic [MAX_LEN-1:0]   history_r;
    logic [LEN_W-1:0]     hist_cnt_r;
    logic                 bit_ready_r;
    logic                 match_r;
    logic [CNT_W-1:0]     match_cnt_r;
    logic                 irq_r;
    logic                 busy_r;

    logic                 accept_s;
    logic [MAX_LEN-1:0]   hist_next_s;
    logic [LEN_W-1:0]     hcnt_next_s;
    logic [MAX_LEN-1:0]   mask_s;
    logic                 match_s;
    logic [CNT_W-1:0]     mcnt_inc_s;
    logic                 thresh_hit_s;
    logic                 irq_set_s;

    // Next-history, pattern compare and threshold evaluation for the bit offered this cycle.
    always_comb begin
        accept_s    = bit_valid & bit_ready_r;
        hist_next_s = (history_r << 1) | {{(MAX_LEN-1){1'b0}}, bit_in};
        if (hist_cnt_r == LEN_W'(MAX_LEN)) begin
            hcnt_next_s = hist_cnt_r;
        end else begin
            hcnt_next_s = hist_cnt_r + LEN_W'(1);
        end
        mask_s       = len_mask(len_r);
        match_s      = accept_s && (hcnt_next_s >= len_r) &&
                       ((hist_next_s & mask_s) == (pattern_r & mask_s));
        mcnt_inc_s   = sat_inc(match_cnt_r);
        thresh_hit_s = (thresh_r != {CNT_W{1'b0}}) && (mcnt_inc_s == thresh_r);
        irq_set_s    = (state_r == ST_RUN) && !stop && match_s && thresh_hit_s;
    end

    // Controller FSM with registered outputs, config capture and detection state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            pattern_r   <= {MAX_LEN{1'b0}};
            len_r       <= LEN_W'(1);
            overlap_r   <= 1'b0;
            thresh_r    <= {CNT_W{1'b0}};
            history_r   <= {MAX_LEN{1'b0}};
            hist_cnt_r  <= {LEN_W{1'b0}};
            bit_ready_r <= 1'b0;
            match_r     <= 1'b0;
            match_cnt_r <= {CNT_W{1'b0}};
            irq_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            match_r <= 1'b0;
            if (irq_set_s) begin
                irq_r <= 1'b1;
            end else if (irq_clr) begin
                irq_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (cfg_we) begin
                        pattern_r <= cfg_pattern;
                        len_r     <= clamp_len(cfg_len);
                        overlap_r <= cfg_overlap;
                        thresh_r  <= cfg_thresh;
                    end
                    if (start && !stop) begin
                        state_r     <= ST_RUN;
                        bit_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                        match_cnt_r <= {CNT_W{1'b0}};
                        history_r   <= {MAX_LEN{1'b0}};
                        hist_cnt_r  <= {LEN_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_r     <= ST_IDLE;
                        bit_ready_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else if (accept_s) begin
                        history_r <= hist_next_s;
                        if (match_s) begin
                            match_r     <= 1'b1;
                            match_cnt_r <= mcnt_inc_s;
                            hist_cnt_r  <= overlap_r ? hcnt_next_s : {LEN_W{1'b0}};
                            if (thresh_hit_s) begin
                                state_r     <= ST_DONE;
                                bit_ready_r <= 1'b0;
                                busy_r      <= 1'b0;
                            end
                        end else begin
                            hist_cnt_r <= hcnt_next_s;
                        end
                    end
                end
                ST_DONE: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                    end else if (start) begin
                        state_r     <= ST_RUN;
                        bit_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                        match_cnt_r <= {CNT_W{1'b0}};
                        history_r   <= {MAX_LEN{1'b0}};
                        hist_cnt_r  <= {LEN_W{1'b0}};
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    bit_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bit_ready = bit_ready_r;
    assign match     = match_r;
    assign match_cnt = match_cnt_r;
    assign irq       = irq_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl: 1100/1010 detection, overlap,
// threshold/irq, config guard and clamp, stop priority and async reset.
module tb_seq_det_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_thresh;
    logic               start;
    logic               stop;
    logic               bit_valid;
    logic               bit_in;
    logic               bit_ready;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               irq;
    logic               irq_clr;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
        .start(start), .stop(stop), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(bit_ready), .match(match), .match_cnt(match_cnt), .irq(irq),
        .irq_clr(irq_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] th);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_thresh = th;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Sends n bits MSB-first from bits[n-1:0]; exp[k] is the match expected after bits[k].
    task automatic run_stream(input string tag, input logic [7:0] bits, input logic [7:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = bits[i];
            tick();
            bit_valid = 1'b0;
            check_eq(tag, {31'd0, match}, {31'd0, exp[i]});
        end
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
        cfg_thresh = 8'h00; start = 1'b0; stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        irq_clr = 1'b0;
        #3;
        check_eq("rst_ready", {31'd0, bit_ready}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_match", {31'd0, match}, 32'd0);
        check_eq("rst_cnt", {24'd0, match_cnt}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Non-overlapping 1100
        cfg(8'b0000_1100, 4'd4, 1'b0, 8'd0);
        do_start();
        check_eq("run_busy", {31'd0, busy}, 32'd1);
        check_eq("run_ready", {31'd0, bit_ready}, 32'd1);
        run_stream("m1100", 8'b1100_1100, 8'b0001_0001, 8);
        check_eq("cnt1100", {24'd0, match_cnt}, 32'd2);
        tick();
        check_eq("m1100_drop", {31'd0, match}, 32'd0);

        // Overlapping 1010 with a stall; stray bit_in during stall must be ignored
        do_stop();
        check_eq("stop_busy", {31'd0, busy}, 32'd0);
        check_eq("stop_cnt_held", {24'd0, match_cnt}, 32'd2);
        cfg(8'b0000_1010, 4'd4, 1'b1, 8'd0);
        do_start();
        run_stream("ov_a", 8'b0000_0010, 8'b0000_0000, 2);
        bit_in = 1'b1;
        tick(); tick(); tick();
        run_stream("ov_b", 8'b0000_1010, 8'b0000_0101, 4);
        check_eq("cnt_ov", {24'd0, match_cnt}, 32'd2);

        do_stop();
        cfg(8'b0000_1010, 4'd4, 1'b0, 8'd0);
        do_start();
        run_stream("nov", 8'b0010_1010, 8'b0000_0100, 6);
        check_eq("cnt_nov", {24'd0, match_cnt}, 32'd1);

        // Threshold and irq
        do_stop();
        cfg(8'h01, 4'd1, 1'b0, 8'd2);
        do_start();
        run_stream("th", 8'b0000_0011, 8'b0000_0011, 3);
        check_eq("th_irq", {31'd0, irq}, 32'd1);
        check_eq("th_ready", {31'd0, bit_ready}, 32'd0);
        check_eq("th_busy", {31'd0, busy}, 32'd0);
        check_eq("th_cnt", {24'd0, match_cnt}, 32'd2);
        run_stream("th_4th", 8'b0000_0001, 8'b0000_0000, 1);
        check_eq("th_cnt_held", {24'd0, match_cnt}, 32'd2);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check_eq("irq_clr", {31'd0, irq}, 32'd0);
        do_start();
        check_eq("restart_busy", {31'd0, busy}, 32'd1);
        check_eq("restart_cnt", {24'd0, match_cnt}, 32'd0);

        // cfg_we in RUN ignored: pattern 1 still detected
        cfg(8'h00, 4'd1, 1'b0, 8'd0);
        run_stream("guard", 8'b0000_0010, 8'b0000_0010, 2);
        check_eq("guard_cnt", {24'd0, match_cnt}, 32'd1);

        // Length 0 clamps to 8
        do_stop();
        cfg(8'hA5, 4'd0, 1'b0, 8'd0);
        do_start();
        run_stream("clamp", 8'hA5, 8'b0000_0001, 8);
        check_eq("clamp_cnt", {24'd0, match_cnt}, 32'd1);

        // stop with start while running
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        check_eq("ss_busy", {31'd0, busy}, 32'd0);
        check_eq("ss_cnt", {24'd0, match_cnt}, 32'd1);

        // stop on the cycle the completing bit is accepted
        do_start();
        run_stream("pri_a", 8'hA5, 8'b0000_0001, 8);
        run_stream("pri_b", 8'b0101_0010, 8'b0000_0000, 7);
        bit_valid = 1'b1; bit_in = 1'b1; stop = 1'b1;
        tick();
        bit_valid = 1'b0; stop = 1'b0;
        check_eq("pri_match", {31'd0, match}, 32'd0);
        check_eq("pri_cnt", {24'd0, match_cnt}, 32'd1);
        check_eq("pri_ready", {31'd0, bit_ready}, 32'd0);

        // Async reset mid-run with match_cnt=3
        cfg(8'h01, 4'd1, 1'b1, 8'd0);
        do_start();
        run_stream("pre_rst", 8'b0000_0111, 8'b0000_0111, 3);
        check_eq("pre_rst_cnt", {24'd0, match_cnt}, 32'd3);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_cnt", {24'd0, match_cnt}, 32'd0);
        check_eq("arst_match", {31'd0, match}, 32'd0);
        check_eq("arst_ready", {31'd0, bit_ready}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check_eq("idle_after_rst", {31'd0, busy}, 32'd0);
        // Config lost: default pattern 0, len 1
        do_start();
        run_stream("dflt", 8'b0000_0001, 8'b0000_0010, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
